// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    // Upper bound on data width handled by bit_rev; callers cast to/from their own width.
    localparam int REV_MAX_W = 1024;

    function automatic logic [REV_MAX_W-1:0] bit_rev(input logic [REV_MAX_W-1:0] d, input int w);
        logic [REV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < REV_MAX_W; i++) begin
            if (i < w) r[i] = d[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the shifter: right shift by DIST when sel_i is set.
// ROTATE_SHIFT_EN adds the wrap path that feeds the shifted-out bits back in at the top.
module shift_level #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             fill_i,
    input  logic             sel_i,
    input  logic             rot_i,
    output logic [WIDTH-1:0] data_o
);

    logic [DIST-1:0] wrap;

`ifdef ROTATE_SHIFT_EN
    assign wrap = rot_i ? data_i[DIST-1:0] : {DIST{fill_i}};
`else
    logic rot_unused;
    assign rot_unused = rot_i;
    assign wrap       = {DIST{fill_i}};
`endif

    assign data_o = sel_i ? {wrap, data_i[WIDTH-1:DIST]} : data_i;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SRL/SRA/SLL(/ROR) barrel shifter with a global-stall valid/ready pipe.
// ROTATE_SHIFT_EN enables op 11 as rotate-right; otherwise op 11 behaves as SRL.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int AMT_W     = $clog2(WIDTH),
    parameter int REG_EVERY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  shift_op_t        in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam int LATENCY = (AMT_W + REG_EVERY - 1) / REG_EVERY;

    logic               advance;
    logic [LATENCY:0]   vld_pipe;
    logic [LATENCY-1:0] vld_q;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_pipe[LATENCY];
    assign out_zero  = out_valid && (out_data == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        vld_q <= '0;
        else if (advance) vld_q <= vld_pipe[LATENCY-1:0];
    end

    // SLL is done as a right shift on bit-reversed data, undone at the exit register.
    logic [WIDTH-1:0] ent_dat;
    logic             ent_fill, ent_rot, ent_rev;

    assign ent_rev  = (in_op == OP_SLL);
    assign ent_fill = (in_op == OP_SRA) && in_data[WIDTH-1];
`ifdef ROTATE_SHIFT_EN
    assign ent_rot  = (in_op == OP_ROR);
`else
    assign ent_rot  = 1'b0;
`endif
    assign ent_dat  = ent_rev ? WIDTH'(bit_rev(REV_MAX_W'(in_data), WIDTH)) : in_data;

    for (genvar l = 0; l < AMT_W; l++) begin : g_lvl
        localparam int DIST = 1 << (AMT_W - 1 - l);

        logic [WIDTH-1:0]   d_in, d_out;
        logic               fill_in, rot_in, rev_in;
        logic [AMT_W-1-l:0] amt_in;   // only the amount bits not yet consumed

        if (l == 0) begin : g_first
            assign d_in    = ent_dat;
            assign fill_in = ent_fill;
            assign rot_in  = ent_rot;
            assign rev_in  = ent_rev;
            assign amt_in  = in_amt;
        end else begin : g_next
            assign d_in    = g_lvl[l-1].g_mid.pipe_dat;
            assign fill_in = g_lvl[l-1].g_mid.pipe_fill;
            assign rot_in  = g_lvl[l-1].g_mid.pipe_rot;
            assign rev_in  = g_lvl[l-1].g_mid.pipe_rev;
            assign amt_in  = g_lvl[l-1].g_mid.pipe_amt;
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (DIST)
        ) u_level (
            .data_i (d_in),
            .fill_i (fill_in),
            .sel_i  (amt_in[AMT_W-1-l]),
            .rot_i  (rot_in),
            .data_o (d_out)
        );

        if (l == AMT_W - 1) begin : g_out
            logic [WIDTH-1:0] data_d, data_q;

            assign data_d = rev_in ? WIDTH'(bit_rev(REV_MAX_W'(d_out), WIDTH)) : d_out;

            always_ff @(posedge clock or posedge reset) begin
                if (reset)        data_q <= '0;
                else if (advance) data_q <= data_d;
            end

            assign out_data = data_q;
        end else begin : g_mid
            logic [WIDTH-1:0]   pipe_dat;
            logic               pipe_fill, pipe_rot, pipe_rev;
            logic [AMT_W-2-l:0] pipe_amt;

            if (((l + 1) % REG_EVERY) == 0) begin : g_reg
                logic [WIDTH-1:0]   dat_q;
                logic               fill_q, rot_q, rev_q;
                logic [AMT_W-2-l:0] amt_q;

                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        dat_q  <= '0;
                        fill_q <= 1'b0;
                        rot_q  <= 1'b0;
                        rev_q  <= 1'b0;
                        amt_q  <= '0;
                    end else if (advance) begin
                        dat_q  <= d_out;
                        fill_q <= fill_in;
                        rot_q  <= rot_in;
                        rev_q  <= rev_in;
                        amt_q  <= amt_in[AMT_W-2-l:0];
                    end
                end

                assign pipe_dat  = dat_q;
                assign pipe_fill = fill_q;
                assign pipe_rot  = rot_q;
                assign pipe_rev  = rev_q;
                assign pipe_amt  = amt_q;
            end else begin : g_pass
                assign pipe_dat  = d_out;
                assign pipe_fill = fill_in;
                assign pipe_rot  = rot_in;
                assign pipe_rev  = rev_in;
                assign pipe_amt  = amt_in[AMT_W-2-l:0];
            end
        end
    end

endmodule
